univ_shift_reg: RTL and testbench
=================================

# univ_shift_reg

Parameterised universal shift register built from per-bit D flip-flops with a shift-count tracker. It sits directly downstream of the single-bit D storage element. It stacks WIDTH of those elements behind a per-bit 4:1 mode mux, giving hold, shift-right, shift-left and parallel-load. A counter reports how many shifts have occurred since the last load and pulses `done` when a full word has been shifted, so the block serves as both SIPO and PISO.

## Interface
- `WIDTH`, 8, register width in bits; legal range 2..32.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset. Low clears all state immediately, independent of `clk`.
- `mode`  in  2  operation select: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- `sin_r`  in  1  serial input entering at bit WIDTH-1 during shift right.
- `sin_l`  in  1  serial input entering at bit 0 during shift left.
- `pdata`  in  WIDTH  parallel load data.
- `q`  out  WIDTH  register contents.
- `sout_r`  out  1  equals `q[0]`, the bit leaving on shift right.
- `sout_l`  out  1  equals `q[WIDTH-1]`, the bit leaving on shift left.
- `cnt`  out  $clog2(WIDTH+1)  shifts since last load or reset; saturates at WIDTH.
- `done`  out  1  one-cycle pulse on the edge where `cnt` reaches WIDTH.

## Operation
- Reset (`rst`=0): `q`=0, `cnt`=0, `done`=0; `sout_r`=`sout_l`=0 follow from `q`. Asynchronous assertion takes effect mid-cycle; state holds while low.
- Hold (00):
  - `q` and `cnt` unchanged.
  - `done`=0.
- Shift right (01):
  - `q` <= {`sin_r`, `q[WIDTH-1:1]`}.
  - `cnt` <= min(`cnt`+1, WIDTH).
- Shift left (10):
  - `q` <= {`q[WIDTH-2:0]`, `sin_l`}.
  - `cnt` increments exactly as for shift right.
- Load (11):
  - `q` <= `pdata`.
  - `cnt` <= 0.
  - `done` <= 0.
- `done` is registered:
  - 1 for exactly one cycle after the edge where `cnt` goes from WIDTH-1 to WIDTH.
  - 0 on every other edge, including further shifts while saturated.
- Direction changes mid-word are legal. `cnt` counts shifts in either direction and does not track direction.
- `mode` is sampled only at rising `clk`. `sin_r`, `sin_l` and `pdata` are ignored outside their modes.
- `sout_r` and `sout_l` are combinational taps of `q`, with no added register.

## Timing
- Every `q` update lands one `clk` edge after the mode is presented. Load-to-visible latency is 1 cycle.
- `done` and `cnt`=WIDTH become visible on the same edge as the WIDTH-th shift.
- Reset release: the first edge with `rst`=1 performs the selected mode normally. No extra wait cycle.
- Reset asserted between edges: `q`, `cnt` and `done` clear without waiting for `clk`. The next operation after release starts from `cnt`=0.
- Saturation: after `cnt`=WIDTH, further shifts keep moving data, `cnt` stays at WIDTH and `done` stays 0.
- Load with `cnt`=WIDTH returns `cnt` to 0 on that edge. A new word is then needed before `done` can pulse again.

## Structure
- Package `shreg_pkg`:
  - `MODE_HOLD`=2'b00, `MODE_SHR`=2'b01, `MODE_SHL`=2'b10, `MODE_LOAD`=2'b11.
  - A typedef for the 2-bit mode.
- Sub-module `dff_ar`: one D flip-flop with asynchronous active-low clear. Ports: `clk`, `rst`, `d`, `q`, `qb`.
- Top-level data path:
  - generate loop of WIDTH `dff_ar` instances.
  - Each instance is fed by a 4:1 mux selecting own `q[i]` / right neighbour (or `sin_r`) / left neighbour (or `sin_l`) / `pdata[i]`.
- `cnt` and `done` are behavioural registers in the top level, with the same clock and reset.

## Test plan
- Reset mid-cycle: load 8'hA5, then drive `rst`=0 halfway between edges -> `q`=0, `cnt`=0, `done`=0 immediately, before the next edge.
- Parallel load then hold: `pdata`=8'h3C, mode 11 for one cycle, then mode 00 for 5 cycles -> `q`=8'h3C throughout, `cnt`=0, `done` never 1.
- PISO right: load 8'hB1, then 8 cycles of mode 01 with `sin_r`=0 -> `sout_r` before each edge reads 1,0,0,0,1,1,0,1. After the 8th edge: `q`=0, `cnt`=8, `done`=1 for that cycle only.
- SIPO left: from reset, 8 cycles of mode 10 with `sin_l` = 1,1,0,0,1,0,1,0 -> `q`=8'hCA, `done` pulses after the 8th shift, `cnt`=8.
- Saturation and reload: after the previous case, 3 more shifts -> `cnt` stays 8, `done`=0. Load 8'hFF -> `cnt`=0; 8 more shifts -> `done` pulses once.
- Mixed direction: load 8'h81, then SHR, SHL, SHR with all serial inputs 0 -> `q`=8'h40, 8'h80, 8'h40; `cnt`=3.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared definitions for the universal shift register:
// operation-select encoding.
package shreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } mode_t;

endpackage

// File: rtl/dff_ar.sv
// Single D storage element with asynchronous
// active-low clear and complementary output.
module dff_ar (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic qb
);

  logic r_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_q <= 1'b0;
    else      r_q <= d;
  end

  assign q  = r_q;
  assign qb = ~r_q;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: per-bit 4:1 mode mux in front
// of dff_ar cells, plus a shift counter with done pulse.
module univ_shift_reg
  import shreg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  mode_t                      mode,
  input  logic                       sin_r,
  input  logic                       sin_l,
  input  logic [WIDTH-1:0]           pdata,
  output logic [WIDTH-1:0]           q,
  output logic                       sout_r,
  output logic                       sout_l,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] FULL = CW'(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_qb;
  logic [WIDTH-1:0] w_hold;
  logic [WIDTH-1:0] w_shr;
  logic [WIDTH-1:0] w_shl;
  logic [WIDTH-1:0] w_d;
  logic [CW-1:0]    r_cnt;
  logic             r_done;

  // hold recirculates through the complement tap
  assign w_hold = ~w_qb;
  assign w_shr  = {sin_r, w_q[WIDTH-1:1]};
  assign w_shl  = {w_q[WIDTH-2:0], sin_l};

  always_comb begin
    w_d = w_hold;
    unique case (mode)
      MODE_HOLD: w_d = w_hold;
      MODE_SHR:  w_d = w_shr;
      MODE_SHL:  w_d = w_shl;
      MODE_LOAD: w_d = pdata;
    endcase
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    dff_ar u_dff (
      .clk (clk),
      .rst (rst),
      .d   (w_d[i]),
      .q   (w_q[i]),
      .qb  (w_qb[i])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      unique case (mode)
        MODE_HOLD: r_done <= 1'b0;
        MODE_SHR, MODE_SHL: begin
          if (r_cnt != FULL) r_cnt <= r_cnt + 1'b1;
          r_done <= (r_cnt == LAST);
        end
        MODE_LOAD: begin
          r_cnt  <= '0;
          r_done <= 1'b0;
        end
      endcase
    end
  end

  assign q      = w_q;
  assign sout_r = w_q[0];
  assign sout_l = w_q[WIDTH-1];
  assign cnt    = r_cnt;
  assign done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg at WIDTH=8.
module tb_univ_shift_reg;
  import shreg_pkg::*;

  logic       clk;
  logic       rst;
  mode_t      mode;
  logic       sin_r;
  logic       sin_l;
  logic [7:0] pdata;
  logic [7:0] q;
  logic       sout_r;
  logic       sout_l;
  logic [3:0] cnt;
  logic       done;

  int total = 0;
  int bad   = 0;

  univ_shift_reg #(.WIDTH(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .mode   (mode),
    .sin_r  (sin_r),
    .sin_l  (sin_l),
    .pdata  (pdata),
    .q      (q),
    .sout_r (sout_r),
    .sout_l (sout_l),
    .cnt    (cnt),
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input mode_t m, input logic sr,
                      input logic sl, input logic [7:0] pd);
    mode  = m;
    sin_r = sr;
    sin_l = sl;
    pdata = pd;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [7:0] piso_v;
  logic [7:0] sipo_v;
  int         pulses;

  initial begin
    rst = 1'b0; mode = MODE_HOLD;
    sin_r = 1'b0; sin_l = 1'b0; pdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_q", q, 8'h00);
    chk("rst_cnt", cnt, 4'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_souts", {sout_l, sout_r}, 2'b00);
    rst = 1'b1;

    // mid-cycle asynchronous reset
    step(MODE_LOAD, 1'b0, 1'b0, 8'hA5);
    chk("ld_a5", q, 8'hA5);
    step(MODE_SHR, 1'b0, 1'b0, 8'h00);
    chk("a5_shr_cnt", cnt, 4'd1);
    mode = MODE_HOLD;
    #3 rst = 1'b0;
    #1;
    chk("async_q", q, 8'h00);
    chk("async_cnt", cnt, 4'd0);
    chk("async_done", done, 1'b0);
    #2 rst = 1'b1;

    // load then hold
    step(MODE_LOAD, 1'b0, 1'b0, 8'h3C);
    for (int i = 0; i < 5; i++) begin
      step(MODE_HOLD, 1'b1, 1'b1, 8'hFF);
      chk("hold_q", q, 8'h3C);
      chk("hold_cnt", cnt, 4'd0);
      chk("hold_done", done, 1'b0);
    end

    // PISO to the right
    step(MODE_LOAD, 1'b0, 1'b0, 8'hB1);
    piso_v = 8'b1011_0001;
    chk("piso_soutl", sout_l, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("piso_sout", sout_r, piso_v[i]);
      step(MODE_SHR, 1'b0, 1'b1, 8'hFF);
      if (i < 7) chk("piso_nodone", done, 1'b0);
    end
    chk("piso_q", q, 8'h00);
    chk("piso_cnt", cnt, 4'd8);
    chk("piso_done", done, 1'b1);
    step(MODE_HOLD, 1'b0, 1'b0, 8'h00);
    chk("piso_done_1cyc", done, 1'b0);
    chk("piso_cnt_hold", cnt, 4'd8);

    // SIPO from the left
    do_reset();
    sipo_v = 8'b1100_1010;
    for (int i = 0; i < 8; i++) begin
      step(MODE_SHL, 1'b1, sipo_v[7-i], 8'h00);
      if (i < 7) chk("sipo_nodone", done, 1'b0);
    end
    chk("sipo_q", q, 8'hCA);
    chk("sipo_cnt", cnt, 4'd8);
    chk("sipo_done", done, 1'b1);

    // saturation then reload
    for (int i = 0; i < 3; i++) begin
      step(MODE_SHL, 1'b0, 1'b0, 8'h00);
      chk("sat_cnt", cnt, 4'd8);
      chk("sat_done", done, 1'b0);
    end
    chk("sat_q", q, 8'h50);
    step(MODE_LOAD, 1'b0, 1'b0, 8'hFF);
    chk("reld_q", q, 8'hFF);
    chk("reld_cnt", cnt, 4'd0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step(MODE_SHR, 1'b0, 1'b0, 8'h00);
      if (done) pulses++;
    end
    chk("reld_done_now", done, 1'b1);
    chk("reld_pulses", pulses, 1);
    chk("reld_q_end", q, 8'h00);

    // mixed direction
    step(MODE_LOAD, 1'b1, 1'b1, 8'h81);
    chk("mix_ld", q, 8'h81);
    step(MODE_SHR, 1'b0, 1'b0, 8'h00);
    chk("mix_shr1", q, 8'h40);
    step(MODE_SHL, 1'b0, 1'b0, 8'h00);
    chk("mix_shl", q, 8'h80);
    step(MODE_SHR, 1'b0, 1'b0, 8'h00);
    chk("mix_shr2", q, 8'h40);
    chk("mix_cnt", cnt, 4'd3);
    chk("mix_done", done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
